// File: rtl/chicken_pkg.sv
// Shared types for the Chicken Cha-Cha-Cha controller: default player count,
// player index type, step direction and the turn sequencer state encoding.
// Used by the turn sequencer, the game-state FSM and the display logic.
package chicken_pkg;

   localparam int MAX_PLAYERS_DEF = 4;
   localparam int PW_DEF          = $clog2(MAX_PLAYERS_DEF);

   typedef logic [PW_DEF-1:0] player_id_t;

   typedef enum logic {
      FWD = 1'b0,
      REV = 1'b1
   } dir_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READY  = 2'd1,
      SEARCH = 2'd2
   } turn_state_t;

endpackage

// File: rtl/edge_rise.sv
// 1-bit rising-edge detector with synchronous active-high reset.
//   clk    : clock
//   rst    : synchronous reset, clears the history bit
//   d_i    : level input
//   rise_o : d_i & ~(d_i last cycle), combinational
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (rst) d_q <= 1'b0;
      else     d_q <= d_i;
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: tracks whose turn it is among cnt (2..MAX_PLAYERS) players,
// advancing one turn per rising edge of advance while skipping eliminated
// players. Flags round wrap, last player standing and no active player.
// Optional feature macro: TURN_SEQ_REVERSE_EN (honour the reverse input).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : pulse, latch clamped num_players, turn=0, dir=fwd
//   num_players    : player count, sampled on start only
//   advance        : next-turn request level, rising edge acts
//   reverse        : step backwards (only with TURN_SEQ_REVERSE_EN)
//   active_mask    : bit i set = player i still in the game
//   turn           : current player index
//   busy           : search in progress, advance edges dropped
//   round_done     : 1-cycle pulse, committed step wrapped past the end
//   last_standing  : 1-cycle pulse, current player is the only one active
//   no_active      : sticky until start/rst, search found nobody active
module turn_sequencer
   import chicken_pkg::*;
#(
   parameter int MAX_PLAYERS = MAX_PLAYERS_DEF,
   parameter int PW          = $clog2(MAX_PLAYERS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [PW:0]            num_players,
   input  logic                   advance,
   input  logic                   reverse,
   input  logic [MAX_PLAYERS-1:0] active_mask,
   output logic [PW-1:0]          turn,
   output logic                   busy,
   output logic                   round_done,
   output logic                   last_standing,
   output logic                   no_active
);

   localparam int CW = PW + 1;
   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] idx_t;

   localparam cnt_t CNT_MIN = cnt_t'(2);
   localparam cnt_t CNT_MAX = cnt_t'(MAX_PLAYERS);

   // One step around the ring of cnt players; never leaves 0..c-1.
   function automatic idx_t step(input idx_t x, input cnt_t c, input dir_t d);
      cnt_t xe;
      xe = {1'b0, x};
      if (d == REV) return (xe == '0) ? idx_t'(c - 1'b1) : idx_t'(xe - 1'b1);
      else          return (xe == c - 1'b1) ? '0 : idx_t'(xe + 1'b1);
   endfunction

   function automatic cnt_t clamp(input cnt_t n);
      if (n < CNT_MIN)      return CNT_MIN;
      else if (n > CNT_MAX) return CNT_MAX;
      else                  return n;
   endfunction

   turn_state_t state_q;
   idx_t        turn_q, cand_q;
   cnt_t        cnt_q;
   logic        busy_q, round_q, last_q, noact_q;
   logic        adv_edge;
   dir_t        adv_dir, search_dir;
   logic [MAX_PLAYERS-1:0] eff_mask;

   edge_rise u_adv_edge (
      .clk    (clk),
      .rst    (rst),
      .d_i    (advance),
      .rise_o (adv_edge)
   );

`ifdef TURN_SEQ_REVERSE_EN
   dir_t dir_q;
   assign adv_dir    = reverse ? REV : FWD;
   assign search_dir = dir_q;
`else
   logic unused_reverse;
   assign unused_reverse = reverse;
   assign adv_dir        = FWD;
   assign search_dir     = FWD;
`endif

   // Players at or beyond the latched count never count as active.
   always_comb begin
      eff_mask = '0;
      for (int i = 0; i < MAX_PLAYERS; i++)
         eff_mask[i] = active_mask[i] & (cnt_t'(i) < cnt_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         turn_q  <= '0;
         cand_q  <= '0;
         cnt_q   <= CNT_MIN;
         busy_q  <= 1'b0;
         round_q <= 1'b0;
         last_q  <= 1'b0;
         noact_q <= 1'b0;
`ifdef TURN_SEQ_REVERSE_EN
         dir_q   <= FWD;
`endif
      end else begin
         round_q <= 1'b0;
         last_q  <= 1'b0;
         if (start) begin
            // start wins over everything, including a search in flight
            cnt_q   <= clamp(num_players);
            turn_q  <= '0;
            noact_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= READY;
`ifdef TURN_SEQ_REVERSE_EN
            dir_q   <= FWD;
`endif
         end else begin
            case (state_q)
               IDLE: ;
               READY: begin
                  if (adv_edge) begin
                     cand_q  <= step(turn_q, cnt_q, adv_dir);
                     busy_q  <= 1'b1;
                     state_q <= SEARCH;
`ifdef TURN_SEQ_REVERSE_EN
                     dir_q   <= adv_dir;
`endif
                  end
               end
               SEARCH: begin
                  if (cand_q == turn_q) begin
                     // walked the whole ring back to ourselves
                     if (eff_mask[turn_q]) last_q  <= 1'b1;
                     else                  noact_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= READY;
                  end else if (eff_mask[cand_q]) begin
                     turn_q  <= cand_q;
                     round_q <= (search_dir == FWD) ? (cand_q <= turn_q)
                                                    : (cand_q >= turn_q);
                     busy_q  <= 1'b0;
                     state_q <= READY;
                  end else begin
                     cand_q <= step(cand_q, cnt_q, search_dir);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      turn          = turn_q;
      busy          = busy_q;
      round_done    = round_q;
      last_standing = last_q;
      no_active     = noact_q;
   end

endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;

   logic       clk, rst, start, advance, reverse;
   logic [2:0] num_players;
   logic [3:0] active_mask;
   logic [1:0] turn;
   logic       busy, round_done, last_standing, no_active;

`ifdef TURN_SEQ_REVERSE_EN
   localparam bit REV_EN = 1'b1;
`else
   localparam bit REV_EN = 1'b0;
`endif

   turn_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_players   (num_players),
      .advance       (advance),
      .reverse       (reverse),
      .active_mask   (active_mask),
      .turn          (turn),
      .busy          (busy),
      .round_done    (round_done),
      .last_standing (last_standing),
      .no_active     (no_active)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int turn;
      int rd;
      int ls;
      int na;
      int lat;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   bit   abort  = 1'b0;

   // reference model state: latched count, current turn, sticky no-active
   int m_cnt   = 2;
   int m_turn  = 0;
   int m_noact = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Walk the ring distance by distance until an active player is found.
   task automatic model_step(input bit rev, output exp_t e);
      int  c, t, idx, kf, idxf;
      bit  found, r;
      c = m_cnt; t = m_turn; r = rev & REV_EN;
      found = 0; kf = 0; idxf = 0;
      for (int k = 1; k <= c; k++) begin
         idx = r ? (((t - k) % c) + c) % c : (t + k) % c;
         if (!found && active_mask[idx]) begin
            found = 1; kf = k; idxf = idx;
         end
      end
      e.turn = t; e.rd = 0; e.ls = 0; e.lat = c;
      if (!found)       m_noact = 1;
      else if (kf == c) e.ls = 1;
      else begin
         e.turn = idxf;
         e.rd   = r ? int'(t - kf < 0) : int'(t + kf >= c);
         e.lat  = kf;
      end
      e.na   = m_noact;
      m_turn = e.turn;
   endtask

   task automatic monitor();
      bit prev = 1'b0;
      int bcnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            if (!prev) bcnt = 0;
            bcnt++;
         end
         if (prev && busy !== 1'b1) begin
            if (abort) abort = 1'b0;
            else if (sbq.size() == 0) chk("unexpected_resolve", 1, 0);
            else begin
               e = sbq.pop_front();
               chk("turn", 32'(turn), e.turn);
               chk("round_done", 32'(round_done), e.rd);
               chk("last_standing", 32'(last_standing), e.ls);
               chk("no_active", 32'(no_active), e.na);
               chk("busy_cycles", bcnt, e.lat);
            end
         end else begin
            chk("idle_pulses", {30'b0, round_done, last_standing}, 0);
         end
         prev = (busy === 1'b1);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sbq.size() != 0 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      chk("resolve_timeout", sbq.size(), 0);
      sbq.delete();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input int n);
      start = 1'b1; num_players = 3'(n);
      @(posedge clk); #1;
      start = 1'b0;
      m_cnt = (n < 2) ? 2 : (n > 4) ? 4 : n;
      m_turn = 0; m_noact = 0;
      @(negedge clk);
      chk("start_turn", 32'(turn), 0);
      chk("start_busy", 32'(busy), 0);
      chk("start_no_active", 32'(no_active), 0);
      @(posedge clk); #1;
   endtask

   // One advance edge held for 'hold' cycles; optional second edge while busy.
   task automatic do_adv(input int hold, input bit dbl, input bit rev);
      exp_t e;
      model_step(rev, e);
      sbq.push_back(e);
      reverse = rev; advance = 1'b1;
      repeat (hold) begin @(posedge clk); #1; end
      advance = 1'b0;
      if (dbl && hold == 1 && e.lat >= 2) begin
         @(posedge clk); #1; advance = 1'b1;
         @(posedge clk); #1; advance = 1'b0;
      end
      wait_idle();
   endtask

   task automatic abort_search(input bit use_rst);
      do_start(4);
      active_mask = 4'b1000;
      abort = 1'b1; reverse = 1'b0; advance = 1'b1;
      @(posedge clk); #1; advance = 1'b0;
      @(posedge clk); #1;
      if (use_rst) rst = 1'b1;
      else begin start = 1'b1; num_players = 3'd3; end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_turn", 32'(turn), 0);
      chk("abort_no_active", 32'(no_active), 0);
      chk("abort_pulses", {30'b0, round_done, last_standing}, 0);
      m_turn = 0; m_noact = 0; m_cnt = use_rst ? 2 : 3;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; advance = 1'b0; reverse = 1'b0;
      num_players = '0; active_mask = '0;
      fork monitor(); join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_turn", 32'(turn), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flags", {29'b0, round_done, last_standing, no_active}, 0);
      @(posedge clk); #1; rst = 1'b0;

      // edge in IDLE is dropped: monitor flags any busy/pulse activity
      advance = 1'b1; @(posedge clk); #1; advance = 1'b0;
      repeat (3) @(posedge clk); #1;

      // 3 players, wrap on third step
      do_start(3); active_mask = 4'b0111;
      repeat (3) do_adv(1, 0, 0);
      // 4 players, player 2 skipped
      do_start(4); active_mask = 4'b1011;
      do_adv(1, 0, 0); do_adv(1, 0, 0);
      // held level and edge during busy
      active_mask = 4'b1001;
      do_adv(10, 0, 0); do_adv(1, 1, 0);
      // last standing then no active (sticky)
      do_start(4); active_mask = 4'b0111;
      do_adv(1, 0, 0); do_adv(1, 0, 0);
      active_mask = 4'b0100; do_adv(1, 0, 0);
      active_mask = 4'b0000; do_adv(1, 0, 0); do_adv(2, 0, 0);
      active_mask = 4'b1111; do_adv(1, 0, 0);
      // reverse card from turn 0
      do_start(4); do_adv(1, 0, 1); do_adv(1, 0, 1);
      // aborts mid-search, then over-range player count
      abort_search(1'b1);
      abort_search(1'b0);
      do_start(7); active_mask = 4'b1111;
      repeat (4) do_adv(1, 0, 0);
      // bits above count ignored
      do_start(2); active_mask = 4'b1100; do_adv(1, 0, 0);

      for (int it = 0; it < 300; it++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) do_start($urandom_range(0, 7));
         else if (r <= 4) begin
            active_mask = 4'($urandom);
            @(posedge clk); #1;
         end else
            do_adv(($urandom_range(0, 7) == 0) ? 10 : $urandom_range(1, 3),
                   1'($urandom), 1'($urandom));
      end

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
